// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU operation codes and immediate formats.
package decode_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_SLTU  = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_AND   = 5'd9,
        ALU_PASSB = 5'd10
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4
    } imm_fmt_e;

    // SUB only exists for register-register forms; OP_IMM bit 30 selects SRAI only.
    function automatic alu_ctrl_e alu_from_func(input logic [2:0] func3,
                                                input logic       f7b5,
                                                input logic       is_reg);
        case (func3)
            3'b000:  alu_from_func = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_func = ALU_SLL;
            3'b010:  alu_from_func = ALU_SLT;
            3'b011:  alu_from_func = ALU_SLTU;
            3'b100:  alu_from_func = ALU_XOR;
            3'b101:  alu_from_func = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_func = ALU_OR;
            default: alu_from_func = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational RV32I immediate generator, sign-extended from instruction bit 31 to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] raw;

    always_comb begin
        raw = '0;
        case (fmt)
            FMT_I:   raw = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   raw = {inst[31:12], 12'b0};
            FMT_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/decode_stage.sv
// Stallable, flushable RV32I decode stage with valid/ready output register.
// Define DECODE_FWD_EN for EX/MEM operand forwarding; otherwise any pending write to a used source stalls.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5,
    parameter int ALUW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [31:0]     in_inst_i,
    output logic [RAW-1:0]  rs1_raddr_o,
    output logic [RAW-1:0]  rs2_raddr_o,
    input  logic [XLEN-1:0] rs1_rdata_i,
    input  logic [XLEN-1:0] rs2_rdata_i,
    input  logic            ex_we_i,
    input  logic            ex_is_load_i,
    input  logic [RAW-1:0]  ex_waddr_i,
    input  logic [XLEN-1:0] ex_wdata_i,
    input  logic            mem_we_i,
    input  logic [RAW-1:0]  mem_waddr_i,
    input  logic [XLEN-1:0] mem_wdata_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_op_a_o,
    output logic [XLEN-1:0] out_op_b_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic [RAW-1:0]  out_waddr_o,
    output logic [ALUW-1:0] out_alu_ctrl_o,
    output logic            out_reg_we_o,
    output logic            out_use_imm_o,
    output logic            out_is_load_o,
    output logic            out_is_store_o,
    output logic            out_illegal_o
);

    logic [6:0]     opcode;
    logic [RAW-1:0] rd;
    logic [2:0]     func3;
    logic [6:0]     func7;

    assign opcode      = in_inst_i[6:0];
    assign rd          = RAW'(in_inst_i[11:7]);
    assign func3       = in_inst_i[14:12];
    assign func7       = in_inst_i[31:25];
    assign rs1_raddr_o = RAW'(in_inst_i[19:15]);
    assign rs2_raddr_o = RAW'(in_inst_i[24:20]);

    imm_fmt_e  fmt;
    alu_ctrl_e alu;
    logic      reg_we, use_imm, is_load, is_store, illegal, use_rs1, use_rs2;

    always_comb begin
        fmt      = FMT_I;
        alu      = ALU_ADD;
        reg_we   = 1'b0;
        use_imm  = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        illegal  = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opcode)
            OP:     begin alu = alu_from_func(func3, func7[5], 1'b1); reg_we = 1'b1;
                          use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_IMM: begin alu = alu_from_func(func3, func7[5], 1'b0); reg_we = 1'b1;
                          use_imm = 1'b1; use_rs1 = 1'b1; end
            LOAD:   begin reg_we = 1'b1; use_imm = 1'b1; is_load = 1'b1; use_rs1 = 1'b1; end
            STORE:  begin fmt = FMT_S; use_imm = 1'b1; is_store = 1'b1;
                          use_rs1 = 1'b1; use_rs2 = 1'b1; end
            BRANCH: begin fmt = FMT_B; alu = ALU_SUB; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            LUI:    begin fmt = FMT_U; alu = ALU_PASSB; reg_we = 1'b1; use_imm = 1'b1; end
            AUIPC:  begin fmt = FMT_U; reg_we = 1'b1; use_imm = 1'b1; end
            JAL:    begin fmt = FMT_J; reg_we = 1'b1; use_imm = 1'b1; end
            JALR:   begin reg_we = 1'b1; use_imm = 1'b1; use_rs1 = 1'b1; end
            default: illegal = 1'b1;
        endcase
        if (rd == '0) reg_we = 1'b0;
    end

    logic [XLEN-1:0] imm;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (in_inst_i),
        .fmt  (fmt),
        .imm  (imm)
    );

    logic            ex_hit1, ex_hit2, mem_hit1, mem_hit2, hazard;
    logic [XLEN-1:0] op_a, op_b;

    assign ex_hit1  = ex_we_i  && (ex_waddr_i  != '0) && (ex_waddr_i  == rs1_raddr_o);
    assign ex_hit2  = ex_we_i  && (ex_waddr_i  != '0) && (ex_waddr_i  == rs2_raddr_o);
    assign mem_hit1 = mem_we_i && (mem_waddr_i != '0) && (mem_waddr_i == rs1_raddr_o);
    assign mem_hit2 = mem_we_i && (mem_waddr_i != '0) && (mem_waddr_i == rs2_raddr_o);

`ifdef DECODE_FWD_EN
    assign hazard = ex_is_load_i && ((use_rs1 && ex_hit1) || (use_rs2 && ex_hit2));

    always_comb begin
        op_a = rs1_rdata_i;
        op_b = rs2_rdata_i;
        if (rs1_raddr_o == '0)            op_a = '0;
        else if (ex_hit1 && !ex_is_load_i) op_a = ex_wdata_i;
        else if (mem_hit1)                op_a = mem_wdata_i;
        if (rs2_raddr_o == '0)            op_b = '0;
        else if (ex_hit2 && !ex_is_load_i) op_b = ex_wdata_i;
        else if (mem_hit2)                op_b = mem_wdata_i;
    end
`else
    assign hazard = (use_rs1 && (ex_hit1 || mem_hit1)) || (use_rs2 && (ex_hit2 || mem_hit2));

    assign op_a = (rs1_raddr_o == '0) ? '0 : rs1_rdata_i;
    assign op_b = (rs2_raddr_o == '0) ? '0 : rs2_rdata_i;
`endif

    logic advance, accept;

    assign advance    = !out_valid_o || out_ready_i;
    assign in_ready_o = advance && !hazard && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o    <= 1'b0;
            out_pc_o       <= '0;
            out_op_a_o     <= '0;
            out_op_b_o     <= '0;
            out_imm_o      <= '0;
            out_waddr_o    <= '0;
            out_alu_ctrl_o <= '0;
            out_reg_we_o   <= 1'b0;
            out_use_imm_o  <= 1'b0;
            out_is_load_o  <= 1'b0;
            out_is_store_o <= 1'b0;
            out_illegal_o  <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (advance) begin
            out_valid_o <= accept;
            if (accept) begin
                out_pc_o       <= in_pc_i;
                out_op_a_o     <= op_a;
                out_op_b_o     <= op_b;
                out_imm_o      <= imm;
                out_waddr_o    <= rd;
                out_alu_ctrl_o <= ALUW'(alu);
                out_reg_we_o   <= reg_we;
                out_use_imm_o  <= use_imm;
                out_is_load_o  <= is_load;
                out_is_store_o <= is_store;
                out_illegal_o  <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage; expectations follow DECODE_FWD_EN when defined.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i, in_ready_o;
    logic [31:0] in_pc_i, in_inst_i;
    logic [4:0]  rs1_raddr_o, rs2_raddr_o;
    logic [31:0] rs1_rdata_i, rs2_rdata_i;
    logic        ex_we_i, ex_is_load_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        mem_we_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        flush_i, out_valid_o, out_ready_i;
    logic [31:0] out_pc_o, out_op_a_o, out_op_b_o, out_imm_o;
    logic [4:0]  out_waddr_o, out_alu_ctrl_o;
    logic        out_reg_we_o, out_use_imm_o, out_is_load_o, out_is_store_o, out_illegal_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Register file model: x[n] reads as 0x1000_0000 + n.
    assign rs1_rdata_i = 32'h1000_0000 | {27'b0, rs1_raddr_o};
    assign rs2_rdata_i = 32'h1000_0000 | {27'b0, rs2_raddr_o};

    decode_stage #(.XLEN(32), .RAW(5), .ALUW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
        .rs1_raddr_o(rs1_raddr_o), .rs2_raddr_o(rs2_raddr_o),
        .rs1_rdata_i(rs1_rdata_i), .rs2_rdata_i(rs2_rdata_i),
        .ex_we_i(ex_we_i), .ex_is_load_i(ex_is_load_i),
        .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_op_a_o(out_op_a_o), .out_op_b_o(out_op_b_o),
        .out_imm_o(out_imm_o), .out_waddr_o(out_waddr_o), .out_alu_ctrl_o(out_alu_ctrl_o),
        .out_reg_we_o(out_reg_we_o), .out_use_imm_o(out_use_imm_o),
        .out_is_load_o(out_is_load_o), .out_is_store_o(out_is_store_o),
        .out_illegal_o(out_illegal_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pipe();
        ex_we_i = 1'b0; ex_is_load_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
        mem_we_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0;
    endtask

    // Present one instruction with no hazard and check it is accepted.
    task automatic issue(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        in_valid_i = 1'b1; in_pc_i = pc; in_inst_i = inst;
        #1 check({tag, "_rdy"}, {31'b0, in_ready_o}, 32'd1);
        tick();
        in_valid_i = 1'b0;
        check({tag, "_vld"}, {31'b0, out_valid_o}, 32'd1);
        check({tag, "_pc"}, out_pc_o, pc);
    endtask

    initial begin
        rst = 1'b1; in_valid_i = 1'b0; in_pc_i = '0; in_inst_i = '0;
        flush_i = 1'b0; out_ready_i = 1'b1;
        clear_pipe();
        tick(); tick();
        check("rst_vld", {31'b0, out_valid_o}, 32'd0);
        check("rst_imm", out_imm_o, 32'd0);
        check("rst_opa", out_op_a_o, 32'd0);
        check("rst_we", {31'b0, out_reg_we_o}, 32'd0);
        rst = 1'b0;
        #1 check("rst_rdy", {31'b0, in_ready_o}, 32'd1);

        // addi x1,x0,5
        issue("addi", 32'h100, 32'h0050_0093);
        check("addi_imm", out_imm_o, 32'd5);
        check("addi_rd", {27'b0, out_waddr_o}, 32'd1);
        check("addi_we", {31'b0, out_reg_we_o}, 32'd1);
        check("addi_ui", {31'b0, out_use_imm_o}, 32'd1);
        check("addi_opa", out_op_a_o, 32'd0);
        check("addi_alu", {27'b0, out_alu_ctrl_o}, 32'd0);
        tick();
        check("bubble_vld", {31'b0, out_valid_o}, 32'd0);

        // addi x1,x0,-1 and jal x1,2048
        issue("addim1", 32'h104, 32'hFFF0_0093);
        check("addim1_imm", out_imm_o, 32'hFFFF_FFFF);
        issue("jal", 32'h108, 32'h0010_00EF);
        check("jal_imm", out_imm_o, 32'h0000_0800);

        // add x2,x1,x1 with EX writing x1=0x10
        ex_we_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'h10;
`ifdef DECODE_FWD_EN
        issue("fwd_ex", 32'h110, 32'h0010_8133);
        check("fwd_ex_a", out_op_a_o, 32'h10);
        check("fwd_ex_b", out_op_b_o, 32'h10);
        mem_we_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h20;
        issue("fwd_pri", 32'h114, 32'h0010_8133);
        check("fwd_pri_a", out_op_a_o, 32'h10);
        ex_we_i = 1'b0;
        issue("fwd_mem", 32'h118, 32'h0010_8133);
        check("fwd_mem_b", out_op_b_o, 32'h20);
        clear_pipe();
`else
        in_valid_i = 1'b1; in_pc_i = 32'h110; in_inst_i = 32'h0010_8133;
        #1 check("stl_ex_rdy", {31'b0, in_ready_o}, 32'd0);
        tick();
        check("stl_ex_vld", {31'b0, out_valid_o}, 32'd0);
        ex_we_i = 1'b0; mem_we_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h10;
        #1 check("stl_mem_rdy", {31'b0, in_ready_o}, 32'd0);
        tick();
        check("stl_mem_vld", {31'b0, out_valid_o}, 32'd0);
        clear_pipe();
        issue("stl_done", 32'h110, 32'h0010_8133);
        check("stl_done_a", out_op_a_o, 32'h1000_0001);
        check("stl_done_b", out_op_b_o, 32'h1000_0001);
`endif

        // lw x1 in EX, then add x3,x1,x2
        ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_waddr_i = 5'd1;
        in_valid_i = 1'b1; in_pc_i = 32'h120; in_inst_i = 32'h0020_81B3;
        #1 check("lu_rdy", {31'b0, in_ready_o}, 32'd0);
        check("lu_raddr", {22'b0, rs1_raddr_o, rs2_raddr_o}, {22'b0, 5'd1, 5'd2});
        tick();
        check("lu_bubble", {31'b0, out_valid_o}, 32'd0);
        clear_pipe();
        mem_we_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h55;
`ifdef DECODE_FWD_EN
        issue("lu_go", 32'h120, 32'h0020_81B3);
        check("lu_go_a", out_op_a_o, 32'h55);
`else
        #1 check("lu_mem_rdy", {31'b0, in_ready_o}, 32'd0);
        tick();
        mem_we_i = 1'b0;
        issue("lu_go", 32'h120, 32'h0020_81B3);
        check("lu_go_a", out_op_a_o, 32'h1000_0001);
`endif
        check("lu_go_b", out_op_b_o, 32'h1000_0002);
        clear_pipe();

        // lui x5,0x12345 ignores its rs1 field (x8) even with a load to x8 in EX
        ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_waddr_i = 5'd8;
        issue("lui", 32'h124, 32'h1234_52B7);
        check("lui_imm", out_imm_o, 32'h1234_5000);
        check("lui_we", {31'b0, out_reg_we_o}, 32'd1);
        clear_pipe();

        // beq x0,x0,-4
        issue("beq", 32'h128, 32'hFE00_0EE3);
        check("beq_imm", out_imm_o, 32'hFFFF_FFFC);
        check("beq_we", {31'b0, out_reg_we_o}, 32'd0);

        // sw x2,8(x1), then backpressure for 3 cycles and a flush during the hold
        issue("sw", 32'h12C, 32'h0020_A423);
        check("sw_imm", out_imm_o, 32'd8);
        check("sw_st", {31'b0, out_is_store_o}, 32'd1);
        check("sw_we", {31'b0, out_reg_we_o}, 32'd0);
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_pc_i = 32'h130; in_inst_i = 32'h0050_0213;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_rdy", {31'b0, in_ready_o}, 32'd0);
            tick();
            check("bp_vld", {31'b0, out_valid_o}, 32'd1);
            check("bp_pc", out_pc_o, 32'h12C);
            check("bp_imm", out_imm_o, 32'd8);
        end
        flush_i = 1'b1;
        #1 check("fl_rdy", {31'b0, in_ready_o}, 32'd0);
        tick();
        check("fl_vld", {31'b0, out_valid_o}, 32'd0);
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;

        // Unknown opcode with rd=1, then addi x0,x0,1
        issue("ill", 32'h140, 32'h0000_00FF);
        check("ill_flag", {31'b0, out_illegal_o}, 32'd1);
        check("ill_we", {31'b0, out_reg_we_o}, 32'd0);
        check("ill_alu", {27'b0, out_alu_ctrl_o}, 32'd0);
        issue("rd0", 32'h144, 32'h0010_0013);
        check("rd0_we", {31'b0, out_reg_we_o}, 32'd0);
        check("rd0_ill", {31'b0, out_illegal_o}, 32'd0);

        // Hazard and flush together: flush wins, nothing issued
        ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_waddr_i = 5'd1;
        flush_i = 1'b1; in_valid_i = 1'b1; in_inst_i = 32'h0020_81B3;
        #1 check("hf_rdy", {31'b0, in_ready_o}, 32'd0);
        tick();
        check("hf_vld", {31'b0, out_valid_o}, 32'd0);
        flush_i = 1'b0; in_valid_i = 1'b0;
        clear_pipe();

        // Reset during a stall drops the held bundle
        issue("pre_rst", 32'h300, 32'h0050_0093);
        out_ready_i = 1'b0;
        tick();
        check("hold_vld", {31'b0, out_valid_o}, 32'd1);
        rst = 1'b1;
        tick();
        check("mrst_vld", {31'b0, out_valid_o}, 32'd0);
        check("mrst_imm", out_imm_o, 32'd0);
        check("mrst_pc", out_pc_o, 32'd0);
        rst = 1'b0; out_ready_i = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised in-order decode stage for the scalar RV32I pipeline, sitting between the fetch/decode pipeline register and the execute stage. It:
- decodes the instruction and generates all five immediate formats;
- reads the register file, with operand forwarding from EX and MEM;
- detects load-use hazards;
- registers its results behind a valid/ready handshake.

It supersedes the purely combinational decode path with a stallable, flushable pipeline stage.

## Interface
Parameters:
- XLEN, 32, datapath width of PC, operands and immediates
- RAW, 5, register address width
- ALUW, 5, width of ALU control code

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid_i  in  1  fetch presents an instruction
- in_ready_o  out  1  stage accepts the instruction this cycle
- in_pc_i  in  XLEN  instruction PC
- in_inst_i  in  32  instruction word
- rs1_raddr_o, rs2_raddr_o  out  RAW  register file read addresses (combinational from in_inst_i)
- rs1_rdata_i, rs2_rdata_i  in  XLEN  register file read data (same cycle)
- ex_we_i, ex_is_load_i  in  1  EX holds a register write / a load
- ex_waddr_i  in  RAW  EX destination
- ex_wdata_i  in  XLEN  EX result
- mem_we_i  in  1  MEM holds a register write
- mem_waddr_i  in  RAW  MEM destination
- mem_wdata_i  in  XLEN  MEM result
- flush_i  in  1  branch/exception redirect, kills the stage
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  execute accepts the bundle
- out_pc_o, out_op_a_o, out_op_b_o, out_imm_o  out  XLEN  registered PC, rs1 value, rs2 value, sign-extended immediate
- out_waddr_o  out  RAW  rd
- out_alu_ctrl_o  out  ALUW  ALU operation code
- out_reg_we_o, out_use_imm_o, out_is_load_o, out_is_store_o, out_illegal_o  out  1  control flags

## Operation
- Field split: opcode [6:0], rd [11:7], func3 [14:12], rs1 [19:15], rs2 [24:20], func7 [31:25].
- Immediates, sign-extended from bit 31 to XLEN:
  - I: [31:20]
  - S: {[31:25], [11:7]}
  - B: {[31], [7], [30:25], [11:8], 0}
  - U: {[31:12], 12'b0}
  - J: {[31], [19:12], [20], [30:21], 0}
- Operand select, per source:
  - address 0 yields 0;
  - otherwise EX match with ex_we_i and not ex_is_load_i yields ex_wdata_i;
  - otherwise MEM match with mem_we_i yields mem_wdata_i;
  - otherwise the register file value.
  - EX has priority over MEM.
- A source is "used" only if the format reads it: U/J use neither; I/load use rs1 only; R/S/B use both.
- Load-use hazard: ex_we_i and ex_is_load_i, ex_waddr_i != 0, and ex_waddr_i equals a used source. The instruction is held (in_ready_o=0) and a bubble is issued.
- Unknown opcode: out_illegal_o=1, out_reg_we_o=0, out_alu_ctrl_o = ADD code.
- out_reg_we_o is forced 0 when rd=0.

## Timing
- Reset: out_valid_o=0 and every out_* data/control output is 0; in_ready_o follows its equation.
- advance = !out_valid_o | out_ready_i.
- in_ready_o = advance & !hazard & !flush_i.
- Latency: exactly 1 cycle from accept (in_valid_i & in_ready_o) to out_valid_o=1.
- On advance with no accept: out_valid_o goes to 0 (bubble); data outputs may hold.
- Backpressure: while out_valid_o & !out_ready_i, all outputs hold stable and in_ready_o=0.
- flush_i has highest priority: out_valid_o=0 next cycle regardless of out_ready_i, and the input is not accepted.
- Hazard and flush in the same cycle: flush wins.
- rst asserted mid-stall drops the held bundle.

## Configuration
- DECODE_FWD_EN defined: EX/MEM forwarding as described; stall only on load-use.
- DECODE_FWD_EN undefined: no forwarding muxes. Any used source matching a pending EX or MEM write (address != 0) stalls. WB-cycle reads rely on the write-first register file.

## Structure
- Shared package decode_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
  - the ALUW-wide ALU code enum;
  - the immediate-format enum.
- Sub-module imm_gen (combinational: instruction plus format in, XLEN immediate out).
- Control decode, forwarding and the output register live in decode_stage.

## Test plan
- addi x1,x0,5 (0x00500093), out_ready_i=1 -> one cycle later: out_valid_o=1, out_imm_o=5, out_waddr_o=1, out_reg_we_o=1, out_use_imm_o=1.
- EX writes x1=0x10 (non-load), add x2,x1,x1 -> out_op_a_o = out_op_b_o = 0x10. With DECODE_FWD_EN undefined -> one stall cycle per pending write instead.
- lw x1 in EX, then add x3,x1,x2 -> in_ready_o=0 for one cycle, a bubble is issued, then accept.
- beq with imm=-4 (0xFE000EE3) -> out_imm_o=0xFFFFFFFC, out_reg_we_o=0.
- out_ready_i=0 for 3 cycles with out_valid_o=1 -> outputs stable and in_ready_o=0; flush_i during the hold -> out_valid_o=0 next cycle.
- Opcode 0x7F -> out_illegal_o=1, out_reg_we_o=0.
